// File: rtl/jb_pa_prot_pkg.sv
// rtl/jb_pa_prot_pkg.sv - shared types and helpers for the PA slew-trip protection stage
package jb_pa_prot_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    TRIPPED = 2'd1,
    HOLDOFF = 2'd2,
    RAMP    = 2'd3
  } slew_trip_state_t;

  localparam int TRIP_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [TRIP_CNT_W-1:0] sat_inc(input logic [TRIP_CNT_W-1:0] v);
    return (v == {TRIP_CNT_W{1'b1}}) ? v : v + {{(TRIP_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/jb_iq_delay_line.sv
// rtl/jb_iq_delay_line.sv - fixed-depth shift register aligning {valid, iq} with the detector flag
module jb_iq_delay_line #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift every cycle; valid travels with the data so gaps are preserved.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/jb_iq_slew_trip_ctrl.sv
// rtl/jb_iq_slew_trip_ctrl.sv - slew-error window counter, PA trip/mute FSM; JB_SLEW_TRIP_RAMP_EN adds a recovery gain ramp
module jb_iq_slew_trip_ctrl
  import jb_pa_prot_pkg::*;
#(
  parameter int IQ_PRECISION = 16,
  parameter int DET_LATENCY  = 5,
  parameter int CNT_W        = 16
`ifdef JB_SLEW_TRIP_RAMP_EN
  , parameter int RAMP_BITS  = 6
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*IQ_PRECISION-1:0] iq_in,
  input  logic                      iq_in_valid,
  input  logic                      iq_slew_error,
  input  logic                      cfg_enable,
  input  logic [CNT_W-1:0]          cfg_err_thresh,
  input  logic [CNT_W-1:0]          cfg_window_len,
  input  logic [CNT_W-1:0]          cfg_holdoff_len,
  input  logic                      cfg_auto_recover,
  input  logic                      trip_clear,
  output logic [2*IQ_PRECISION-1:0] iq_out,
  output logic                      iq_out_valid,
  output logic                      pa_trip,
  output logic [TRIP_CNT_W-1:0]     trip_count
);

  localparam int IQ_W = 2 * IQ_PRECISION;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   CNT_ONE_X = {{CNT_W{1'b0}}, 1'b1};

  logic [IQ_W:0]          dl_out;
  logic                   dv;
  logic [IQ_W-1:0]        d_iq;
  slew_trip_state_t       state_q;
  logic [CNT_W-1:0]       win_cnt_q, err_cnt_q, hold_cnt_q;
  logic [TRIP_CNT_W-1:0]  trip_cnt_q;
  logic                   pa_trip_q;
  logic [CNT_W-1:0]       thresh_eff, win_eff;
  logic                   win_wrap, trip_now, hold_done, mute;

`ifdef JB_SLEW_TRIP_RAMP_EN
  localparam logic [RAMP_BITS:0] GAIN_ONE  = {{RAMP_BITS{1'b0}}, 1'b1};
  localparam logic [RAMP_BITS:0] GAIN_FULL = {1'b1, {RAMP_BITS{1'b0}}};
  logic [RAMP_BITS:0] gain_q;
`endif

  jb_iq_delay_line #(.WIDTH(IQ_W + 1), .DEPTH(DET_LATENCY)) u_dly (
    .clk   (clk),
    .reset (reset),
    .din   ({iq_in_valid, iq_in}),
    .dout  (dl_out)
  );

  assign {dv, d_iq} = dl_out;
  assign pa_trip    = pa_trip_q;
  assign trip_count = trip_cnt_q;

  // Trip decision and mute; zero-length thresholds/windows behave as one.
  always_comb begin
    thresh_eff = (cfg_err_thresh == '0) ? CNT_ONE : cfg_err_thresh;
    win_eff    = (cfg_window_len == '0) ? CNT_ONE : cfg_window_len;
    win_wrap   = (win_cnt_q == win_eff - CNT_ONE);
    trip_now   = cfg_enable && (state_q == ARMED) && dv && iq_slew_error &&
                 (({1'b0, err_cnt_q} + CNT_ONE_X) >= {1'b0, thresh_eff});
    hold_done  = (cfg_holdoff_len == '0) ||
                 (dv && ((hold_cnt_q + CNT_ONE) >= cfg_holdoff_len));
    mute       = cfg_enable && (trip_now || (state_q == TRIPPED) || (state_q == HOLDOFF));
  end

  // Protection FSM with window/error/holdoff counters and registered pa_trip.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARMED;
      win_cnt_q  <= '0;
      err_cnt_q  <= '0;
      hold_cnt_q <= '0;
      trip_cnt_q <= '0;
      pa_trip_q  <= 1'b0;
`ifdef JB_SLEW_TRIP_RAMP_EN
      gain_q     <= '0;
`endif
    end else if (!cfg_enable) begin
      state_q    <= ARMED;
      win_cnt_q  <= '0;
      err_cnt_q  <= '0;
      hold_cnt_q <= '0;
      pa_trip_q  <= 1'b0;
`ifdef JB_SLEW_TRIP_RAMP_EN
      gain_q     <= '0;
`endif
    end else begin
      case (state_q)
        ARMED: begin
          if (trip_now) begin
            state_q    <= TRIPPED;
            pa_trip_q  <= 1'b1;
            trip_cnt_q <= sat_inc(trip_cnt_q);
            win_cnt_q  <= '0;
            err_cnt_q  <= '0;
          end else if (dv) begin
            // An error on the wrap sample could only matter for the trip test above.
            if (win_wrap) begin
              win_cnt_q <= '0;
              err_cnt_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + CNT_ONE;
              if (iq_slew_error) err_cnt_q <= err_cnt_q + CNT_ONE;
            end
          end
        end
        TRIPPED: begin
          if (cfg_auto_recover || trip_clear) begin
            state_q    <= HOLDOFF;
            hold_cnt_q <= '0;
          end
        end
        HOLDOFF: begin
          if (hold_done) begin
`ifdef JB_SLEW_TRIP_RAMP_EN
            state_q    <= RAMP;
            gain_q     <= '0;
`else
            state_q    <= ARMED;
`endif
            pa_trip_q  <= 1'b0;
            hold_cnt_q <= '0;
          end else if (dv) begin
            hold_cnt_q <= hold_cnt_q + CNT_ONE;
          end
        end
`ifdef JB_SLEW_TRIP_RAMP_EN
        RAMP: begin
          if (dv) begin
            if (gain_q == GAIN_FULL) state_q <= ARMED;
            else                     gain_q  <= gain_q + GAIN_ONE;
          end
        end
`endif
        default: state_q <= ARMED;
      endcase
    end
  end

`ifdef JB_SLEW_TRIP_RAMP_EN
  logic [IQ_W-1:0]                      s1_iq;
  logic                                 s1_valid;
  logic [RAMP_BITS:0]                   s1_gain;
  logic signed [IQ_PRECISION+RAMP_BITS+1:0] prod_i, prod_q;

  // First output stage: mute and capture the gain that applies to this sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_iq    <= '0;
      s1_valid <= 1'b0;
      s1_gain  <= '0;
    end else begin
      s1_iq    <= mute ? '0 : d_iq;
      s1_valid <= dv;
      s1_gain  <= (cfg_enable && (state_q == RAMP)) ? gain_q : GAIN_FULL;
    end
  end

  // Scale each component by gain / 2^RAMP_BITS with an arithmetic shift.
  always_comb begin
    prod_i = '0;
    prod_q = '0;
    prod_i = ($signed(s1_iq[IQ_PRECISION-1:0]) * $signed({1'b0, s1_gain})) >>> RAMP_BITS;
    prod_q = ($signed(s1_iq[IQ_W-1:IQ_PRECISION]) * $signed({1'b0, s1_gain})) >>> RAMP_BITS;
  end

  // Second output stage: scaled sample to the PA path.
  always_ff @(posedge clk) begin
    if (reset) begin
      iq_out       <= '0;
      iq_out_valid <= 1'b0;
    end else begin
      iq_out       <= {prod_q[IQ_PRECISION-1:0], prod_i[IQ_PRECISION-1:0]};
      iq_out_valid <= s1_valid;
    end
  end
`else
  // Output register: muted or passed-through sample, valid never gapped.
  always_ff @(posedge clk) begin
    if (reset) begin
      iq_out       <= '0;
      iq_out_valid <= 1'b0;
    end else begin
      iq_out       <= mute ? '0 : d_iq;
      iq_out_valid <= dv;
    end
  end
`endif

endmodule
